// File: rtl/dmem_pkg.sv
// dmem_pkg: shared opcodes, FSM encoding and default sizing for the data-memory responder.
package dmem_pkg;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam int DEPTH_DEF       = 256;
  localparam int WAIT_CYCLES_DEF = 2;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port DEPTH x 32 RAM, synchronous read and write.
module dmem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      else rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_resp.sv
// dmem_resp: one-at-a-time load/store responder with fixed wait states.
// Optional misalignment rejection under DMEM_ALIGN_CHECK_EN.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  state_t state, state_n;
  logic wr_q, err_q, acc, mis, unused_addr;
  logic [AW-1:0] word_q;
  logic [31:0] wdata_q, ram_q;
  logic [15:0] cnt;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign acc = req_valid && req_ready;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  // RAM output only changes in ACCESS, so it stays stable through RESP
  assign rsp_rdata = (rsp_valid && !wr_q && !err_q) ? ram_q : '0;
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = |req_addr[1:0];
  assign rsp_err = rsp_valid && err_q;
`else
  assign mis = 1'b0;
  assign rsp_err = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !acc ? IDLE : mis ? RESP : (WAIT_CYCLES > 0) ? WAIT : ACCESS;
      WAIT:    state_n = (cnt == '0) ? ACCESS : WAIT;
      ACCESS:  state_n = RESP;
      default: state_n = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      if (acc) begin
        wr_q    <= req_wr;
        err_q   <= mis;
        word_q  <= req_addr[AW+1:2];
        wdata_q <= req_wdata;
        cnt     <= (WAIT_CYCLES > 0) ? 16'(WAIT_CYCLES - 1) : '0;
      end else if (state == WAIT) cnt <= cnt - 16'd1;
    end
  dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk(clk),
    .en(state == ACCESS),
    .we(wr_q),
    .addr(word_q),
    .wdata(wdata_q),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed vectors for dmem_resp (default and WAIT_CYCLES=0 instances).
module tb_dmem_resp;
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid [2];
  logic req_wr [2];
  logic rsp_ready [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic rdy0, vld0, er0, rdy1, vld1, er1;
  logic [31:0] rd0, rd1;
  int checks = 0;
  int errors = 0;
  vec_t vt [9];

  always #5 clk = ~clk;

  dmem_resp u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(rdy0), .req_wr(req_wr[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(vld0), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rd0), .rsp_err(er0)
  );
  dmem_resp #(.WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(rdy1), .req_wr(req_wr[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(vld1), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rd1), .rsp_err(er1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Present a request, wait for its accept, then count cycles until rsp_valid.
  task automatic issue(input int s, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat);
    int t = 0;
    @(negedge clk);
    req_valid[s] = 1'b1;
    req_wr[s]    = wr;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    while (!(s != 0 ? rdy1 : rdy0) && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[s] = 1'b0;
    req_addr[s]  = 'x;
    lat = 1;
    while (!(s != 0 ? vld1 : vld0) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take(input int s);
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[s] = 1'b0;
  endtask

  task automatic xact(input int s, input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input int exp_lat,
                      input logic exp_er);
    int lat;
    issue(s, wr, addr, wdata, lat);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " rdata"}, s != 0 ? rd1 : rd0, exp_rd);
    chk1({name, " err"}, s != 0 ? er1 : er0, exp_er);
    take(s);
    chk({name, " back to idle"}, {30'b0, s != 0 ? rdy1 : rdy0, s != 0 ? vld1 : vld0}, 32'h2);
  endtask

  initial begin
    int lat;
    vt[0] = '{1'b1, 32'h0000_0010, 32'h1111_1111, 32'h0, 4};
    vt[1] = '{1'b1, 32'h0000_0040, 32'h1234_5678, 32'h0, 4};
    vt[2] = '{1'b0, 32'h0000_0040, 32'h0,         32'h1234_5678, 4};
    vt[3] = '{1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 32'h0, 4};
    vt[4] = '{1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5, 4};
    vt[5] = '{1'b1, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 4};
    vt[6] = '{1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 32'h0, 4};
    vt[7] = '{1'b0, 32'h0000_03FC, 32'h0,         32'h0BAD_F00D, 4};
    vt[8] = '{1'b0, 32'h0000_0408, 32'h0,         32'hCAFE_F00D, 4};
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_wr[i]    = 1'b0;
      rsp_ready[i] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
    end
    @(negedge clk);
    chk1("reset req_ready", rdy0, 1'b1);
    chk1("reset rsp_valid", vld0, 1'b0);
    chk("reset rsp_rdata", rd0, 32'h0);
    chk1("reset rsp_err", er0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++)
      xact(0, $sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].lat, 1'b0);
    // store aborted by reset while waiting must never reach the RAM
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_wr[0]    = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk1("wait req_ready", rdy0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk1("rst in wait req_ready", rdy0, 1'b1);
    chk1("rst in wait rsp_valid", vld0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    xact(0, "lw after aborted sw", 1'b0, 32'h10, 32'h0, 32'h1111_1111, 4, 1'b0);
    issue(0, 1'b0, 32'h40, 32'h0, lat);
    chk1("pending rsp_valid", vld0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("rst in resp rsp_valid", vld0, 1'b0);
    chk("rst in resp rsp_rdata", rd0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue(0, 1'b0, 32'h08, 32'h0, lat);
    chk("bp latency", 32'(lat), 32'd4);
    for (int i = 0; i < 5; i++) begin
      req_valid[0] = (i % 2) == 0;
      req_wr[0]    = 1'b1;
      req_addr[0]  = 32'h08;
      req_wdata[0] = 32'h9999_9999;
      @(negedge clk);
      chk1($sformatf("bp%0d rsp_valid", i), vld0, 1'b1);
      chk($sformatf("bp%0d rsp_rdata", i), rd0, 32'hCAFE_F00D);
      chk1($sformatf("bp%0d req_ready", i), rdy0, 1'b0);
    end
    req_valid[0] = 1'b0;
    take(0);
    chk1("bp released req_ready", rdy0, 1'b1);
    @(negedge clk);
    chk1("bp extra not taken", rdy0, 1'b1);
    xact(0, "bp data intact", 1'b0, 32'h08, 32'h0, 32'hCAFE_F00D, 4, 1'b0);
    xact(1, "w0 sw", 1'b1, 32'h0C, 32'h7777_7777, 32'h0, 2, 1'b0);
    xact(1, "w0 lw", 1'b0, 32'h0C, 32'h0, 32'h7777_7777, 2, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    xact(0, "misaligned sw", 1'b1, 32'h42, 32'hFFFF_FFFF, 32'h0, 1, 1'b1);
    xact(0, "misaligned lw", 1'b0, 32'h41, 32'h0, 32'h0, 1, 1'b1);
    xact(0, "lw after misaligned sw", 1'b0, 32'h40, 32'h0, 32'h1234_5678, 4, 1'b0);
`else
    xact(0, "truncated sw", 1'b1, 32'h42, 32'hFFFF_FFFF, 32'h0, 4, 1'b0);
    xact(0, "truncated lw", 1'b0, 32'h43, 32'h0, 32'hFFFF_FFFF, 4, 1'b0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
